// File: rtl/bcd_key_if.sv
// bcd_key_if: request/grant and BCD valid-ready bundle for bcd_key_arbiter
interface bcd_key_if;
    logic [9:0] req;
    logic       out_ready;
    logic       out_valid;
    logic [3:0] bcd;
    logic [9:0] grant;
    logic       timeout;
    modport master (output req, out_ready, input out_valid, bcd, grant, timeout);
    modport slave (input req, out_ready, output out_valid, bcd, grant, timeout);
endinterface

// File: rtl/bcd_key_arbiter.sv
// bcd_key_arbiter: round-robin share of one BCD channel among ten decimal requests
module bcd_key_arbiter #(
    parameter int unsigned PTR_RESET = 0,
    parameter int unsigned TIMEOUT   = 16,
    parameter int unsigned CNT_W     = 8
) (
    input logic       clk,
    input logic       rst_n,
    bcd_key_if.slave  bus
);
    typedef enum logic {IDLE, HOLD} state_t;
    state_t state, state_nx;
    logic [3:0] idx, idx_nx, ptr, ptr_nx, inc;
    logic [CNT_W-1:0] wait_cnt, wait_nx;
    logic to_q, to_nx;
    logic [4:0] pi, pa;

    function automatic logic [4:0] pick(input logic [9:0] r, input logic [3:0] s);
        logic [4:0] res;
        logic [4:0] d;
        res = '0;
        for (int j = 9; j >= 0; j--) begin
            d = 5'(s) + 5'(j);
            d = d > 5'd9 ? d - 5'd10 : d;
            if (r[d[3:0]]) res = {1'b1, d[3:0]};
        end
        return res;
    endfunction

    assign inc = idx == 4'd9 ? 4'd0 : idx + 4'd1;
    assign bus.out_valid = state == HOLD;
    assign bus.bcd = state == HOLD ? idx : 4'd0;
    assign bus.grant = state == HOLD ? 10'd1 << idx : 10'd0;
    assign bus.timeout = to_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= 4'd0;
            ptr      <= 4'(PTR_RESET);
            wait_cnt <= '0;
            to_q     <= 1'b0;
        end else begin
            state    <= state_nx;
            idx      <= idx_nx;
            ptr      <= ptr_nx;
            wait_cnt <= wait_nx;
            to_q     <= to_nx;
        end
    end

    // An accept re-arbitrates in the same cycle from the slot after the served digit
    always_comb begin
        pi = pick(bus.req, ptr);
        pa = pick(bus.req, inc);
        state_nx = state;
        idx_nx = idx;
        ptr_nx = ptr;
        wait_nx = wait_cnt;
        to_nx = 1'b0;
        if (state == IDLE) begin
            state_nx = pi[4] ? HOLD : IDLE;
            idx_nx = pi[4] ? pi[3:0] : idx;
            wait_nx = '0;
        end else if (bus.out_ready) begin
            ptr_nx = inc;
            idx_nx = pa[4] ? pa[3:0] : idx;
            state_nx = pa[4] ? HOLD : IDLE;
            wait_nx = '0;
        end else if (TIMEOUT != 0 && wait_cnt == CNT_W'(TIMEOUT - 1)) begin
            ptr_nx = inc;
            state_nx = IDLE;
            to_nx = 1'b1;
        end else begin
            wait_nx = wait_cnt + CNT_W'(1);
        end
    end
endmodule

// File: doc/bcd_key_arbiter.md
Name: bcd_key_arbiter

Overview:
- Sequential front end for the decimal-to-BCD encoder path.
- Ten decimal request lines (D0..D9) may be active together.
- The block shares the single BCD output channel among them using round-robin arbitration.
- It presents one BCD code at a time on a valid/ready handshake, with an optional stall timeout. Downstream consumers see one clean BCD digit per transaction instead of an OR-merged, corrupt code.

Parameters:
- PTR_RESET, 0: index (0..9) holding highest priority after reset.
- TIMEOUT, 16: max cycles a grant waits for out_ready before being dropped. 0 = never drop.
- CNT_W, 8: width of the wait counter. TIMEOUT must be < 2^CNT_W.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req  in  10  decimal requests, bit i = digit i. Level-sensitive.
- out_ready  in  1  consumer accepts the current code.
- out_valid  out  1  bcd/grant hold a valid transaction.
- bcd  out  4  BCD code of the granted digit (0000..1001).
- grant  out  10  one-hot grant to the served digit. All-zero when idle.
- timeout  out  1  one-cycle pulse when a grant is dropped on timeout.

Behaviour:
- Reset value of every state element and output:
  - state=IDLE, out_valid=0, bcd=0000, grant=0, timeout=0.
  - ptr=PTR_RESET, wait_cnt=0.
- Reset is asynchronous assert and takes effect mid-transaction. The in-flight code is discarded with no timeout pulse.
- Arbitration function:
  - Choose the first set bit of req scanning ptr, ptr+1, … 9, 0, …, ptr-1 (wrap 9->0).
  - Result idx is 0..9. bcd=idx as 4-bit binary.
  - D0 is a real request and encodes 0000 with out_valid=1.
- States: IDLE, HOLD.
- IDLE:
  - If req!=0, register idx.
  - Next cycle: state=HOLD, out_valid=1, bcd=idx, grant=1<<idx, wait_cnt=0.
  - Latency is 1 cycle from req sampled to out_valid.
  - If req==0, stay IDLE with outputs zero.
- HOLD:
  - bcd, grant and out_valid stay stable until accept or timeout.
  - Changes on req, including the granted bit dropping, do not retract or alter the transaction.
- Accept (out_valid & out_ready, same edge):
  - ptr <= (idx+1) mod 10.
  - In that same cycle, arbitrate over current req starting at (idx+1) mod 10.
  - If any bit is set, load the new idx and stay HOLD. This gives back-to-back transactions, one per cycle.
  - Otherwise go IDLE with out_valid=0.
  - A requester holding req high is re-served only after every other active requester has had a turn.
- Timeout (TIMEOUT>0):
  - In HOLD without out_ready, wait_cnt increments each cycle.
  - When wait_cnt==TIMEOUT-1 and out_ready=0, the next cycle has: timeout=1 for one cycle, out_valid=0, grant=0, ptr <= (idx+1) mod 10, state=IDLE.
  - An out_ready arriving on the same cycle as the expiry wins: it counts as a normal accept with no timeout pulse.
- No invalid codes: bcd never exceeds 1001. grant is always one-hot or zero. grant and out_valid are always consistent.
- ptr is updated only on accept or timeout, never in IDLE.

Test Plan:
- Single request: reset, req=0000000001 (D0) for 1 cycle, out_ready=1 -> one cycle later out_valid=1, bcd=0000, grant=0000000001; accepted, then IDLE with out_valid=0.
- Fair sharing: req=1010001000 (D3,D7,D9) held, out_ready=1 -> bcd sequence 0011, 0111, 1001, 0011, … one per cycle with no bubbles.
- Stall: req=D5 only, out_ready=0 for 5 cycles then 1 (TIMEOUT=16) -> bcd=0101 stable for 6 cycles; accept on cycle 6; no timeout pulse; req toggling during the stall has no effect.
- Timeout: TIMEOUT=4, req=D8, out_ready held 0 -> out_valid high 4 cycles, then timeout=1 for one cycle, out_valid=0, and next grant starts scanning at D9.
- Wrap and reset: PTR_RESET=9, req=D9|D0 -> first bcd=1001, then 0000; assert rst_n=0 mid-HOLD -> out_valid, grant and bcd go to 0 immediately; after release, first grant is D9 again.
